// File: rtl/dsa_verify.sv
// DSA signature verifier: range-checks (r, s), then sequences modinv, two
// modmult and two modexp cores through w, u1/u2, a/b, t and v = t mod q.

module ARS_modmult1 #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    logic             run, phase;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, ar, dbl, step;

    function automatic logic [WIDTH-1:0] red(input logic [WIDTH:0] x, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] d;
        d = x - {1'b0, m};
        return (x >= {1'b0, m}) ? d[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    // Phase 0 reduces a mod n bit-serially; phase 1 is MSB-first interleaved multiply by b.
    always_comb begin
        dbl  = red({acc, 1'b0}, n);
        step = red({acc, a[cnt]}, n);
        if (phase)
            step = b[cnt] ? red({1'b0, dbl} + {1'b0, ar}, n) : dbl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run   <= 1'b0;
            phase <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            ar    <= '0;
            ready <= 1'b0;
        end else if (!run && !ready && ds) begin
            run   <= 1'b1;
            phase <= 1'b0;
            cnt   <= CW'(WIDTH-1);
            acc   <= '0;
        end else if (run) begin
            if (!phase) begin
                if (cnt == '0) begin
                    ar    <= step;
                    acc   <= '0;
                    phase <= 1'b1;
                    cnt   <= CW'(WIDTH-1);
                end else begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                end
            end else begin
                acc <= step;
                if (cnt == '0) begin
                    run   <= 1'b0;
                    ready <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign result = acc;
endmodule

module ARS_modexp #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             ready,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {E_IDLE, E_SQ, E_MUL, E_DONE} est_t;

    est_t             est, est_n;
    logic             go, mm_rdy, mm_done, last;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] acc, mm_res;

    // go is low for one cycle before every multiply so the multiplier gets a fresh launch.
    ARS_modmult1 #(.WIDTH(WIDTH)) u_mm (
        .clk(clk), .reset(reset || !go), .ds(go),
        .a(acc), .b((est == E_MUL) ? base : acc), .n(modulus),
        .ready(mm_rdy), .result(mm_res)
    );

    assign mm_done = go && mm_rdy;
    assign last    = (idx == '0);

    always_ff @(posedge clk) begin
        if (reset) est <= E_IDLE;
        else       est <= est_n;
    end

    always_comb begin
        est_n = est;
        case (est)
            E_IDLE:  if (ds) est_n = E_SQ;
            E_SQ:    if (mm_done) est_n = exponent[idx] ? E_MUL : (last ? E_DONE : E_SQ);
            E_MUL:   if (mm_done) est_n = last ? E_DONE : E_SQ;
            default: est_n = est;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            go  <= 1'b0;
            idx <= '0;
            acc <= '0;
        end else begin
            go <= (est == E_SQ || est == E_MUL) && !mm_done;
            if (est == E_IDLE && ds) begin
                acc <= WIDTH'(1);
                idx <= CW'(WIDTH-1);
            end else if (mm_done) begin
                acc <= mm_res;
                if (!last && (est == E_MUL || !exponent[idx]))
                    idx <= idx - 1'b1;
            end
        end
    end

    assign ready  = (est == E_DONE);
    assign result = acc;
endmodule

module ARS_modinv #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic             rdy,
    output logic [WIDTH-1:0] result
);
    logic go, ex_rdy;

    always_ff @(posedge clk) begin
        if (reset) go <= 1'b0;
        else       go <= en;
    end

    // m is prime, so a^(m-2) mod m is the inverse.
    ARS_modexp #(.WIDTH(WIDTH)) u_ex (
        .clk(clk), .reset(reset || !en || !go), .ds(go),
        .base(a), .exponent(m - WIDTH'(2)), .modulus(m),
        .ready(ex_rdy), .result(result)
    );

    assign rdy = go && en && ex_rdy;
endmodule

module dsa_verify #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] Hm,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             err_range
);
    typedef enum logic [3:0] {IDLE, CHECK, INV, MULT, EXP, PROD, RED, CMP, DONE} st_t;

    st_t              st, st_n;
    logic             lch, bad;
    logic [WIDTH-1:0] p_l, q_l, g_l, y_l, hm_l, r_l, s_l;
    logic [WIDTH-1:0] w, u1, u2, ea, eb, t, v;

    logic             inv_rst, inv_en, inv_rdy;
    logic             ma_rst, ma_ds, ma_rdy, mb_rst, mb_ds, mb_rdy;
    logic             e1_rst, e1_ds, e1_rdy, e2_rst, e2_ds, e2_rdy;
    logic [WIDTH-1:0] inv_res, ma_res, mb_res, e1_res, e2_res;
    logic [WIDTH-1:0] ma_a, ma_b, ma_n;
    logic             ma_ok, mb_ok, e1_ok, e2_ok;

    ARS_modinv #(.WIDTH(WIDTH)) u_inv (
        .clk(clk), .reset(inv_rst), .en(inv_en), .a(s_l), .m(q_l), .rdy(inv_rdy), .result(inv_res)
    );
    ARS_modmult1 #(.WIDTH(WIDTH)) u_ma (
        .clk(clk), .reset(ma_rst), .ds(ma_ds), .a(ma_a), .b(ma_b), .n(ma_n), .ready(ma_rdy), .result(ma_res)
    );
    ARS_modmult1 #(.WIDTH(WIDTH)) u_mb (
        .clk(clk), .reset(mb_rst), .ds(mb_ds), .a(r_l), .b(w), .n(q_l), .ready(mb_rdy), .result(mb_res)
    );
    ARS_modexp #(.WIDTH(WIDTH)) u_e1 (
        .clk(clk), .reset(e1_rst), .ds(e1_ds), .base(g_l), .exponent(u1), .modulus(p_l), .ready(e1_rdy), .result(e1_res)
    );
    ARS_modexp #(.WIDTH(WIDTH)) u_e2 (
        .clk(clk), .reset(e2_rst), .ds(e2_ds), .base(y_l), .exponent(u2), .modulus(p_l), .ready(e2_rdy), .result(e2_res)
    );

    // lch is low in the first cycle of each state: that cycle is the core launch (reset) cycle,
    // and a ready left over from the previous phase must not be trusted.
    assign ma_ok = lch && ma_rdy;
    assign mb_ok = lch && mb_rdy;
    assign e1_ok = lch && e1_rdy;
    assign e2_ok = lch && e2_rdy;
    assign bad   = (r_l == '0) || (r_l >= q_l) || (s_l == '0) || (s_l >= q_l);

    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (start) st_n = CHECK;
            CHECK:   st_n = bad ? DONE : INV;
            INV:     if (inv_rdy) st_n = MULT;
            MULT:    if (ma_ok && mb_ok) st_n = EXP;
            EXP:     if (e1_ok && e2_ok) st_n = PROD;
            PROD:    if (ma_ok) st_n = RED;
            RED:     if (ma_ok) st_n = CMP;
            CMP:     st_n = DONE;
            DONE:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = (st != IDLE) && (st != DONE);
        done    = (st == DONE);
        inv_rst = 1'b1;  inv_en = 1'b0;
        ma_rst  = 1'b1;  ma_ds  = 1'b0;
        mb_rst  = 1'b1;  mb_ds  = 1'b0;
        e1_rst  = 1'b1;  e1_ds  = 1'b0;
        e2_rst  = 1'b1;  e2_ds  = 1'b0;
        ma_a    = '0;    ma_b   = '0;   ma_n = '0;
        case (st)
            INV: begin
                inv_rst = 1'b0; inv_en = 1'b1;
            end
            MULT: begin
                ma_rst = !lch; ma_ds = lch;
                mb_rst = !lch; mb_ds = lch;
                ma_a = hm_l; ma_b = w; ma_n = q_l;
            end
            EXP: begin
                e1_rst = !lch; e1_ds = lch;
                e2_rst = !lch; e2_ds = lch;
            end
            PROD: begin
                ma_rst = !lch; ma_ds = lch;
                ma_a = ea; ma_b = eb; ma_n = p_l;
            end
            RED: begin
                ma_rst = !lch; ma_ds = lch;
                ma_a = t; ma_b = WIDTH'(1); ma_n = q_l;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lch <= 1'b0;
            p_l <= '0; q_l <= '0; g_l <= '0; y_l <= '0; hm_l <= '0; r_l <= '0; s_l <= '0;
            w <= '0; u1 <= '0; u2 <= '0; ea <= '0; eb <= '0; t <= '0; v <= '0;
            valid <= 1'b0;
            err_range <= 1'b0;
        end else begin
            lch <= (st_n == st);
            case (st)
                IDLE: if (start) begin
                    p_l <= p; q_l <= q; g_l <= g; y_l <= y; hm_l <= Hm; r_l <= r; s_l <= s;
                end
                CHECK: if (bad) begin
                    valid <= 1'b0;
                    err_range <= 1'b1;
                end
                INV:  if (inv_rdy) w <= inv_res;
                MULT: begin
                    if (ma_ok) u1 <= ma_res;
                    if (mb_ok) u2 <= mb_res;
                end
                EXP: begin
                    if (e1_ok) ea <= e1_res;
                    if (e2_ok) eb <= e2_res;
                end
                PROD: if (ma_ok) t <= ma_res;
                RED:  if (ma_ok) v <= ma_res;
                CMP: begin
                    valid <= (v == r_l);
                    err_range <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dsa_verify.sv
// Randomized scoreboard bench for dsa_verify with a plain-arithmetic DSA reference model.

module tb_dsa_verify;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset, start;
    logic [W-1:0] p, q, g, y, hm, r, s;
    logic busy, done, valid, err_range;

    always #5 clk = ~clk;

    dsa_verify #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p(p), .q(q), .g(g), .y(y), .Hm(hm), .r(r), .s(s),
        .busy(busy), .done(done), .valid(valid), .err_range(err_range)
    );

    typedef struct { bit v; bit e; int lat; int t0; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0, failures = 0, ndone = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint pw(input longint b, input longint e, input longint m);
        longint res = 1 % m;
        for (longint i = 0; i < e; i++) res = (res * b) % m;
        return res;
    endfunction

    function automatic longint inv_b(input longint a, input longint m);
        for (longint i = 1; i < m; i++) if ((a * i) % m == 1) return i;
        return 0;
    endfunction

    // {valid, err_range}
    function automatic logic [1:0] model(input longint pp, qq, gg, yy, hh, rr, ss);
        longint w, u1, u2, a, b, v;
        if (rr == 0 || rr >= qq || ss == 0 || ss >= qq) return 2'b01;
        w  = inv_b(ss, qq);
        u1 = (hh * w) % qq;
        u2 = (rr * w) % qq;
        a  = pw(gg, u1, pp);
        b  = pw(yy, u2, pp);
        v  = ((a * b) % pp) % qq;
        return {(v == rr), 1'b0};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            ndone++;
            chk("busy_done_excl", busy & done, 0);
            chk("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("valid", valid, mon_e.v);
                chk("err_range", err_range, mon_e.e);
                if (mon_e.lat >= 0) chk("range_latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
    end

    // mode 0: plain run; 1: re-pulse start and scramble inputs while busy; 2: reset during EXP
    task automatic run_case(input longint pp, qq, gg, yy, hh, rr, ss, input int mode, input bit chk_hold);
        exp_t e;
        logic [1:0] m;
        int n0;
        bit bz_ok, quiet, got;
        m = model(pp, qq, gg, yy, hh, rr, ss);
        e.v = m[1]; e.e = m[0]; e.lat = m[0] ? 2 : -1;
        @(posedge clk); #1;
        if (chk_hold) chk("valid_held", valid, 1);
        p = W'(pp); q = W'(qq); g = W'(gg); y = W'(yy); hm = W'(hh); r = W'(rr); s = W'(ss);
        start = 1'b1;
        e.t0 = cyc;
        sbq.push_back(e);
        n0 = ndone;
        @(posedge clk); #1;
        start = 1'b0;
        if (mode == 1) begin
            for (int k = 0; k < 2; k++) begin
                repeat (5) @(posedge clk);
                #1;
                start = 1'b1; s = s ^ 16'h1; r = r + 16'h1; hm = ~hm; g = g + 16'h1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        if (mode == 2) begin
            got = 0;
            for (int i = 0; i < 20000 && !got; i++) begin
                @(negedge clk);
                if (!dut.e1_rst) got = 1;
            end
            chk("reached_exp", got, 1);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_valid", valid, 0);
            chk("abort_err", err_range, 0);
            chk("abort_cores_reset", {dut.ma_rst, dut.mb_rst, dut.e1_rst, dut.e2_rst, dut.inv_en}, 5'b11110);
            void'(sbq.pop_back());
            repeat (20) @(negedge clk);
            chk("abort_no_done", ndone - n0, 0);
            return;
        end
        bz_ok = 1; quiet = 1; got = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (!busy) bz_ok = 0;
            if (!dut.ma_rst || !dut.mb_rst || !dut.e1_rst || !dut.e2_rst || dut.inv_en) quiet = 0;
        end
        chk("done_seen", got, 1);
        chk("busy_during_run", bz_ok, 1);
        if (e.e) chk("cores_stay_reset", quiet, 1);
        if (!got) begin
            sbq.delete();
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
        end
        if (mode == 1) begin
            repeat (20) @(negedge clk);
            chk("single_done", ndone - n0, 1);
        end
    endtask

    initial begin
        longint pp, qq, gg, xx, yy, hh, rr, ss, kk;
        int sel;
        reset = 1'b1; start = 1'b0;
        p = '0; q = '0; g = '0; y = '0; hm = '0; r = '0; s = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err_range, 0);
        reset = 1'b0;

        run_case(23, 11, 4, 18, 7, 1, 2, 0, 0);
        run_case(23, 11, 4, 18, 7, 1, 3, 0, 0);
        run_case(23, 11, 4, 18, 7, 0, 2, 0, 0);
        run_case(23, 11, 4, 18, 7, 11, 2, 0, 0);
        run_case(23, 11, 4, 18, 7, 1, 0, 0, 0);
        run_case(23, 11, 4, 18, 7, 1, 2, 1, 0);
        run_case(23, 11, 4, 18, 7, 1, 2, 2, 0);
        run_case(23, 11, 4, 18, 7, 1, 2, 0, 0);
        run_case(23, 11, 4, 18, 7, 1, 2, 0, 0);
        chk("valid_after_done", valid, 1);
        run_case(23, 11, 4, 18, 7, 1, 3, 0, 1);

        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 2);
            pp = (sel == 0) ? 23 : (sel == 1) ? 59 : 263;
            qq = (sel == 0) ? 11 : (sel == 1) ? 29 : 131;
            gg = 4;
            xx = $urandom_range(1, int'(qq) - 1);
            yy = pw(gg, xx, pp);
            hh = longint'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) begin
                kk = $urandom_range(1, int'(qq) - 1);
                rr = pw(gg, kk, pp) % qq;
                ss = (inv_b(kk, qq) * ((hh % qq) + xx * rr)) % qq;
            end else begin
                rr = $urandom_range(0, int'(qq) + 1);
                ss = $urandom_range(0, int'(qq) + 1);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_case(pp, qq, gg, yy, hh, rr, ss, 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
